// File: rtl/mult_share_ctrl_pkg.sv
// Shared state type and helpers for the multiplier-sharing sequencer.
// Counter widths are derived from TIMEOUT / LOAD_CYCLES through cnt_w().
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int MAX_REQ         = 8;
    localparam int DEF_LOAD_CYCLES = 2;
    localparam int DEF_TIMEOUT     = 64;

    // Bits needed by a down-counter that starts at n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req at or above ptr, wrapping modulo n.
    function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int idx;
        rr_next = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (req[idx[2:0]]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: lowest requester at or after ptr_i wins.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o
);

    int sel;

    always_comb begin
        sel     = rr_next(MAX_REQ'(req_i), int'(ptr_i), N_REQ);
        any_o   = |req_i;
        index_o = IDX_W'(sel);
        grant_o = any_o ? (N_REQ'(1) << index_o) : '0;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one shift-add multiplier among N_REQ requesters with
// round-robin grant, start pulse, end_op timeout and per-requester response.
//
// state | meaning
// IDLE  | multiplier held in reset, waiting for a request to grant
// LOAD  | operands applied, mul_rst held for LOAD_CYCLES cycles
// RUN   | multiplier running, waiting for end_op or timeout
// RESP  | response offered to the owner until it takes it
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int W           = 8,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [2*W-1:0]             rsp_result,
    output logic                       rsp_err,
    output logic                       mul_rst,
    output logic [W-1:0]               mul_a,
    output logic [W-1:0]               mul_b,
    input  logic [2*W-1:0]             mul_result,
    input  logic                       mul_end_op,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int LD_W  = cnt_w(LOAD_CYCLES);
    localparam int RUN_W = cnt_w(TIMEOUT);
    localparam logic [LD_W-1:0]  LD_LAST   = LD_W'(LOAD_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_FIRST = RUN_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     mul_a_q, mul_a_d;
    logic [W-1:0]     mul_b_q, mul_b_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .index_o (arb_idx),
        .any_o   (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            ld_cnt_q  <= '0;
            run_cnt_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            ld_cnt_q  <= ld_cnt_d;
            run_cnt_q <= run_cnt_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        ld_cnt_d  = ld_cnt_q;
        run_cnt_d = run_cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    mul_a_d   = req_a[arb_idx*W +: W];
                    mul_b_d   = req_b[arb_idx*W +: W];
                    grant_d   = arb_idx;
                    rr_ptr_d  = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    ld_cnt_d  = LD_LAST;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (ld_cnt_q == '0) begin
                    run_cnt_d = RUN_FIRST;
                    state_d   = RUN;
                end else begin
                    ld_cnt_d = ld_cnt_q - 1'b1;
                end
            end
            RUN: begin
                // end_op can still be stale from the previous operation in the first RUN cycle
                if (mul_end_op && (run_cnt_q != RUN_FIRST)) begin
                    result_d = mul_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (run_cnt_q == '0) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    run_cnt_d = run_cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mul_rst    = (state_q == IDLE) || (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign grant_id   = grant_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed vector table, hand sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_mult_share_ctrl;

    localparam int N_REQ       = 4;
    localparam int W           = 8;
    localparam int LOAD_CYCLES = 2;
    localparam int TIMEOUT     = 64;
    localparam int IDX_W       = 2;
    localparam int NO_END      = 1000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N_REQ*W-1:0]   req_a, req_b;
    logic [2*W-1:0]       rsp_result, mul_result;
    logic                 rsp_err, mul_rst, mul_end_op, busy;
    logic [W-1:0]         mul_a, mul_b;
    logic [IDX_W-1:0]     grant_id;

    logic [W-1:0] op_a [N_REQ];
    logic [W-1:0] op_b [N_REQ];
    int n_cmp = 0;
    int n_bad = 0;
    int mdel  = 16;
    int m_cnt = 0;
    int m_ptr = 0;

    typedef struct {
        int idx; int a; int b; int d; int res; int err; int lat; int hold;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N_REQ; i++) begin : g_pack
        assign req_a[i*W +: W] = op_a[i];
        assign req_b[i*W +: W] = op_b[i];
    end

    // Multiplier stand-in: end_op rises mdel cycles after its reset is released.
    always @(posedge clk) begin
        if (mul_rst) m_cnt <= 0;
        else if (m_cnt < NO_END) m_cnt <= m_cnt + 1;
    end
    assign mul_end_op = !mul_rst && (m_cnt >= mdel);
    assign mul_result = 16'(mul_a) * 16'(mul_b);

    mult_share_ctrl #(
        .N_REQ(N_REQ), .W(W), .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_end_op(mul_end_op),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return 0;
    endfunction

    // RUN cycle on which the block leaves RUN: end_op visible from cycle d+1, masked in cycle 1.
    function automatic int run_len(input int d);
        int k;
        k = (d + 1 < 2) ? 2 : d + 1;
        return (k <= TIMEOUT) ? k : TIMEOUT;
    endfunction

    function automatic bit times_out(input int d);
        return (((d + 1 < 2) ? 2 : d + 1) > TIMEOUT);
    endfunction

    // Entered at a negedge with req_valid already driven.
    task automatic txn(input int exp_g, input int exp_res, input int exp_err,
                       input int exp_lat, input int hold);
        int wc, lat;
        #1;
        wc = 0;
        while (req_ready == '0 && wc < 50) begin @(negedge clk); #1; wc++; end
        chk("req_ready", req_ready, 1 << exp_g);
        @(posedge clk);
        @(negedge clk);
        req_valid[exp_g] = 1'b0;
        m_ptr = (exp_g + 1) % N_REQ;
        chk("grant_id", grant_id, exp_g);
        chk("busy_run", busy, 1);
        chk("mul_a", mul_a, op_a[exp_g]);
        #1 chk("ready_while_busy", req_ready, 0);
        lat = 1;
        while (rsp_valid == '0 && lat < 200) begin @(negedge clk); lat++; end
        chk("latency", lat, exp_lat);
        chk("rsp_valid", rsp_valid, 1 << exp_g);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = N_REQ'($urandom) & ~(N_REQ'(1) << exp_g);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1 << exp_g);
            chk("hold_result", rsp_result, exp_res);
            chk("hold_ready", req_ready, 0);
            chk("hold_mul_rst", mul_rst, 0);
        end
        rsp_ready = N_REQ'(1) << exp_g;
        @(negedge clk);
        rsp_ready = '0;
        chk("rsp_done", rsp_valid, 0);
        chk("mul_rst_idle", mul_rst, 1);
        chk("busy_idle", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mul_rst"}, mul_rst, 1);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, gap, d, res;
        bit to;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end

        tbl[0] = '{0,   3,   5, 16,    15, 0, 20, 10};
        tbl[1] = '{2,  13,  11,  0,   143, 0,  5, 0};
        tbl[2] = '{1, 255,   1,  1,   255, 0,  5, 1};
        tbl[3] = '{3, 200, 200,  2, 40000, 0,  6, 0};
        tbl[4] = '{0,  17,  19, 63,   323, 0, 67, 0};
        tbl[5] = '{1,  17,  19, 64,     0, 1, 67, 2};
        tbl[6] = '{2,   9,   9, NO_END, 0, 1, 67, 0};
        tbl[7] = '{3, 250,   3, 16,   750, 0, 20, 0};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin sweeps from a fresh pointer, twice.
        for (int s = 0; s < 2; s++) begin
            op_a[0] = 8'd255; op_b[0] = 8'd255;
            op_a[1] = 8'd10;  op_b[1] = 8'd12;
            op_a[2] = 8'd127; op_b[2] = 8'd201;
            op_a[3] = 8'd0;   op_b[3] = 8'd123;
            mdel = 16;
            req_valid = '1;
            txn(0, 65025, 0, 20, 0);
            txn(1, 120, 0, 20, 0);
            txn(2, 25527, 0, 20, 2);
            txn(3, 0, 0, 20, 0);
        end

        for (int v = 0; v < 8; v++) begin
            op_a[tbl[v].idx] = W'(tbl[v].a);
            op_b[tbl[v].idx] = W'(tbl[v].b);
            mdel = tbl[v].d;
            req_valid[tbl[v].idx] = 1'b1;
            txn(tbl[v].idx, tbl[v].res, tbl[v].err, tbl[v].lat, tbl[v].hold);
        end

        // Fairness: requester 1 always valid, 0 and 2 take turns.
        mdel = 4;
        gap = 0;
        op_a[0] = W'($urandom); op_b[0] = W'($urandom);
        op_a[1] = W'($urandom); op_b[1] = W'($urandom);
        req_valid = 4'b0011;
        for (int t = 0; t < 8; t++) begin
            g = model_pick(req_valid, m_ptr);
            txn(g, int'(op_a[g]) * int'(op_b[g]), 0, 8, 0);
            gap = (g == 1) ? 0 : gap + 1;
            chk("fair_gap_ok", (gap <= N_REQ - 1), 1);
            if (g == 1) begin op_a[1] = W'($urandom); op_b[1] = W'($urandom); req_valid[1] = 1'b1; end
            if (g == 0) begin op_a[2] = W'($urandom); op_b[2] = W'($urandom); req_valid[2] = 1'b1; end
            if (g == 2) begin op_a[0] = W'($urandom); op_b[0] = W'($urandom); req_valid[0] = 1'b1; end
        end
        req_valid = '0;

        // Reset in the middle of RUN.
        op_a[0] = 8'd13; op_b[0] = 8'd11;
        mdel = 16;
        req_valid[0] = 1'b1;
        #1;
        chk("mr_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("mr_in_run", mul_rst, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mr_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        txn(0, 143, 0, 20, 0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && ($urandom_range(1) == 1)) begin
                    op_a[i] = W'($urandom); op_b[i] = W'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                g = $urandom_range(N_REQ - 1);
                op_a[g] = W'($urandom); op_b[g] = W'($urandom);
                req_valid[g] = 1'b1;
            end
            mdel = (t % 6 == 5) ? NO_END : $urandom_range(70);
            g  = model_pick(req_valid, m_ptr);
            to = times_out(mdel);
            d  = run_len(mdel);
            res = to ? 0 : int'(op_a[g]) * int'(op_b[g]);
            txn(g, res, int'(to), 1 + LOAD_CYCLES + d, $urandom_range(3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
